hazard_match_pipe: RTL and testbench

// - Producer side of the hazard-unit interface: pipelines register addresses and control bits D->E->M->W.
// - Generates the Match_*, RegWrite*, MemToRegE, PCSrc* and BranchTakenE inputs the hazard unit consumes.
// - Obeys the hazard unit's returned FlushE and StallD.
// - Sits between decode/condition logic and the hazard unit, beside the datapath pipeline registers.

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/hazard_match_pipe_stage_reg.sv | 28 ++
 rtl/hazard_match_pipe.sv | 136 +++++++++++++
 tb/tb_hazard_match_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard-unit producer pipeline.
// Stage control bundle, stage payloads and the forwarding-match helper.
package hazard_pkg;

  localparam int REG_AW = 4;
  localparam int PC_REG = 15;

  typedef struct packed {
    logic valid;
    logic regWrite;
    logic memToReg;
    logic pcSrc;
    logic branch;
  } stage_ctl_t;

  // E carries both sources for the forwarding compares; M and W only need the destination.
  typedef struct packed {
    stage_ctl_t          ctl;
    logic [REG_AW-1:0]   ra1;
    logic [REG_AW-1:0]   ra2;
    logic [REG_AW-1:0]   wa3;
  } stage_e_t;

  typedef struct packed {
    stage_ctl_t          ctl;
    logic [REG_AW-1:0]   wa3;
  } stage_mw_t;

  // R15 reads return PC+8 from the datapath, so a source of R15 never matches.
  function automatic logic srcMatch(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] dst,
    input logic              srcValid,
    input logic              dstValid
  );
    return srcValid & dstValid & (src == dst) & (src != REG_AW'(PC_REG));
  endfunction

endpackage

// File: rtl/hazard_match_pipe_stage_reg.sv
// Generic pipeline stage register: async reset, synchronous flush to a bubble.
// An all-zero word is a bubble because the valid flag sits in it.
module stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Stage storage: reset and flush both load a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= '0;
    end else if (flush) begin
      q_r <= '0;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/hazard_match_pipe.sv
// Producer side of the hazard interface: carries addresses/control D->E->M->W
// and generates the match, write-enable and PC-source signals the hazard unit consumes.
module hazard_match_pipe
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              MemToRegD,
  input  logic              PCSrcD,
  input  logic              BranchD,
  input  logic              CondExE,
  input  logic              StallD,
  input  logic              FlushE,
  output logic              Match_1E_M,
  output logic              Match_1E_W,
  output logic              Match_2E_M,
  output logic              Match_2E_W,
  output logic              Match_12D_E,
  output logic              MemToRegE,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              PCSrcE,
  output logic              PCSrcM,
  output logic              PCSrcW,
  output logic              BranchTakenE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_e_t         dIn_s;
  stage_e_t         eStage_r;
  stage_mw_t        mIn_s;
  stage_mw_t        mStage_r;
  stage_mw_t        wStage_r;
  logic [CNT_W-1:0] stallCnt_r;
  logic [CNT_W-1:0] flushCnt_r;
  logic             unusedBits_s;

  // Decode inputs packed into an E payload; a decoded instruction is always valid.
  always_comb begin
    dIn_s              = '0;
    dIn_s.ctl.valid    = 1'b1;
    dIn_s.ctl.regWrite = RegWriteD;
    dIn_s.ctl.memToReg = MemToRegD;
    dIn_s.ctl.pcSrc    = PCSrcD;
    dIn_s.ctl.branch   = BranchD;
    dIn_s.ra1          = RA1D;
    dIn_s.ra2          = RA2D;
    dIn_s.wa3          = WA3D;
  end

  // The condition check resolves in E, so side effects leaving E are qualified here.
  always_comb begin
    mIn_s              = '0;
    mIn_s.ctl.valid    = eStage_r.ctl.valid;
    mIn_s.ctl.regWrite = eStage_r.ctl.regWrite & CondExE;
    mIn_s.ctl.memToReg = eStage_r.ctl.memToReg & CondExE;
    mIn_s.ctl.pcSrc    = eStage_r.ctl.pcSrc & CondExE;
    mIn_s.ctl.branch   = eStage_r.ctl.branch & CondExE;
    mIn_s.wa3          = eStage_r.wa3;
  end

  stage_reg #(.W($bits(stage_e_t))) uStageE (
    .clk   (clk),
    .reset (reset),
    .flush (FlushE),
    .d     (dIn_s),
    .q     (eStage_r)
  );

  stage_reg #(.W($bits(stage_mw_t))) uStageM (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .d     (mIn_s),
    .q     (mStage_r)
  );

  stage_reg #(.W($bits(stage_mw_t))) uStageW (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .d     (mStage_r),
    .q     (wStage_r)
  );

  // Forwarding and load-use compares; every compare needs both stages valid.
  always_comb begin
    Match_1E_M  = srcMatch(eStage_r.ra1, mStage_r.wa3, eStage_r.ctl.valid, mStage_r.ctl.valid);
    Match_1E_W  = srcMatch(eStage_r.ra1, wStage_r.wa3, eStage_r.ctl.valid, wStage_r.ctl.valid);
    Match_2E_M  = srcMatch(eStage_r.ra2, mStage_r.wa3, eStage_r.ctl.valid, mStage_r.ctl.valid);
    Match_2E_W  = srcMatch(eStage_r.ra2, wStage_r.wa3, eStage_r.ctl.valid, wStage_r.ctl.valid);
    Match_12D_E = srcMatch(RA1D, eStage_r.wa3, 1'b1, eStage_r.ctl.valid)
                | srcMatch(RA2D, eStage_r.wa3, 1'b1, eStage_r.ctl.valid);
  end

  assign MemToRegE    = eStage_r.ctl.memToReg;
  assign PCSrcE       = eStage_r.ctl.pcSrc & CondExE;
  assign BranchTakenE = eStage_r.ctl.branch & CondExE;
  assign RegWriteM    = mStage_r.ctl.regWrite;
  assign PCSrcM       = mStage_r.ctl.pcSrc;
  assign RegWriteW    = wStage_r.ctl.regWrite;
  assign PCSrcW       = wStage_r.ctl.pcSrc;

  assign unusedBits_s = ^{mStage_r.ctl.memToReg, mStage_r.ctl.branch,
                          wStage_r.ctl.memToReg, wStage_r.ctl.branch};

  // Stall/flush performance counters; free-running wrap on overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt_r <= '0;
      flushCnt_r <= '0;
    end else begin
      if (StallD) begin
        stallCnt_r <= stallCnt_r + CNT_W'(1);
      end else begin
        stallCnt_r <= stallCnt_r;
      end
      if (FlushE) begin
        flushCnt_r <= flushCnt_r + CNT_W'(1);
      end else begin
        flushCnt_r <= flushCnt_r;
      end
    end
  end

  assign stall_cnt = stallCnt_r;
  assign flush_cnt = flushCnt_r;

endmodule

// File: tb/tb_hazard_match_pipe.sv
// Directed bench for hazard_match_pipe with hand-computed expectations.
module tb_hazard_match_pipe;

  logic        clk;
  logic        reset;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteD, MemToRegD, PCSrcD, BranchD;
  logic        CondExE, StallD, FlushE;
  logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic        MemToRegE, RegWriteM, RegWriteW;
  logic        PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic [31:0] stall_cnt, flush_cnt;

  int vectors;
  int miscompares;

  hazard_match_pipe #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3D         (WA3D),
    .RegWriteD    (RegWriteD),
    .MemToRegD    (MemToRegD),
    .PCSrcD       (PCSrcD),
    .BranchD      (BranchD),
    .CondExE      (CondExE),
    .StallD       (StallD),
    .FlushE       (FlushE),
    .Match_1E_M   (Match_1E_M),
    .Match_1E_W   (Match_1E_W),
    .Match_2E_M   (Match_2E_M),
    .Match_2E_W   (Match_2E_W),
    .Match_12D_E  (Match_12D_E),
    .MemToRegE    (MemToRegE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCSrcW       (PCSrcW),
    .BranchTakenE (BranchTakenE),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle decode slot: all addresses R15 so nothing can match.
  task automatic setD(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                      input logic rw, input logic mtr, input logic pcs, input logic br);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemToRegD = mtr; PCSrcD = pcs; BranchD = br;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    CondExE = 1'b1; StallD = 1'b0; FlushE = 1'b0;
    setD(4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_match1EM", {31'd0, Match_1E_M}, 32'd0);
    chk("rst_regwrM", {31'd0, RegWriteM}, 32'd0);
    chk("rst_stallcnt", stall_cnt, 32'd0);
    chk("rst_flushcnt", flush_cnt, 32'd0);
    tick();
    reset = 1'b0;

    // Forward from M, then from W
    setD(4'd15, 4'd15, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    setD(4'd3, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("fwd_12DE", {31'd0, Match_12D_E}, 32'd1);
    tick();
    #2;
    chk("fwd_1EM", {31'd0, Match_1E_M}, 32'd1);
    chk("fwd_regwrM", {31'd0, RegWriteM}, 32'd1);
    chk("fwd_1EW_early", {31'd0, Match_1E_W}, 32'd0);
    tick();
    #2;
    chk("fwd_1EW", {31'd0, Match_1E_W}, 32'd1);
    chk("fwd_1EM_gone", {31'd0, Match_1E_M}, 32'd0);
    chk("fwd_regwrW", {31'd0, RegWriteW}, 32'd1);

    // Source 2 forwarding
    setD(4'd15, 4'd15, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    setD(4'd15, 4'd7, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    chk("fwd_2EM", {31'd0, Match_2E_M}, 32'd1);
    tick();
    #2;
    chk("fwd_2EW", {31'd0, Match_2E_W}, 32'd1);
    chk("fwd_2EM_gone", {31'd0, Match_2E_M}, 32'd0);

    // Load-use: stall D and flush E
    setD(4'd15, 4'd15, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    setD(4'd15, 4'd2, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("lu_12DE", {31'd0, Match_12D_E}, 32'd1);
    chk("lu_memtoregE", {31'd0, MemToRegE}, 32'd1);
    StallD = 1'b1; FlushE = 1'b1;
    tick();
    #2;
    chk("lu_memtoregE_bubble", {31'd0, MemToRegE}, 32'd0);
    chk("lu_regwrM", {31'd0, RegWriteM}, 32'd0);
    chk("lu_stallcnt", stall_cnt, 32'd1);
    chk("lu_flushcnt", flush_cnt, 32'd1);
    StallD = 1'b0; FlushE = 1'b0;
    setD(4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_bubble_12DE", {31'd0, Match_12D_E}, 32'd0);
    tick();
    #2;
    chk("lu_bubble_1EM", {31'd0, Match_1E_M}, 32'd0);
    chk("lu_stallcnt_hold", stall_cnt, 32'd1);

    // R15 is never matched
    setD(4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    setD(4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("pc_12DE", {31'd0, Match_12D_E}, 32'd0);
    tick();
    #2;
    chk("pc_1EM", {31'd0, Match_1E_M}, 32'd0);
    chk("pc_regwrM", {31'd0, RegWriteM}, 32'd1);
    tick();
    #2;
    chk("pc_1EW", {31'd0, Match_1E_W}, 32'd0);

    // Condition fail squashes writes
    setD(4'd15, 4'd15, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    setD(4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("cond_pcsrcE_pass", {31'd0, PCSrcE}, 32'd1);
    CondExE = 1'b0;
    #1;
    chk("cond_pcsrcE_fail", {31'd0, PCSrcE}, 32'd0);
    tick();
    #2;
    chk("cond_regwrM", {31'd0, RegWriteM}, 32'd0);
    chk("cond_pcsrcM", {31'd0, PCSrcM}, 32'd0);
    CondExE = 1'b1;

    // PC write with condition passing reaches W
    setD(4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    setD(4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    chk("pcs_pcsrcM", {31'd0, PCSrcM}, 32'd1);
    tick();
    #2;
    chk("pcs_pcsrcW", {31'd0, PCSrcW}, 32'd1);
    chk("pcs_pcsrcM_next", {31'd0, PCSrcM}, 32'd0);

    // Branch taken, then flushed
    setD(4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    setD(4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("br_taken", {31'd0, BranchTakenE}, 32'd1);
    FlushE = 1'b1;
    tick();
    #2;
    chk("br_flushed", {31'd0, BranchTakenE}, 32'd0);
    chk("br_flushcnt", flush_cnt, 32'd2);
    FlushE = 1'b0;

    // Async reset between edges
    setD(4'd15, 4'd15, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    setD(4'd3, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    chk("ar_pre_regwrM", {31'd0, RegWriteM}, 32'd1);
    chk("ar_pre_1EM", {31'd0, Match_1E_M}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_regwrM", {31'd0, RegWriteM}, 32'd0);
    chk("ar_1EM", {31'd0, Match_1E_M}, 32'd0);
    chk("ar_stallcnt", stall_cnt, 32'd0);
    chk("ar_flushcnt", flush_cnt, 32'd0);
    #1;
    reset = 1'b0;
    setD(4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    chk("ar_post_regwrW", {31'd0, RegWriteW}, 32'd0);
    chk("ar_post_regwrM", {31'd0, RegWriteM}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
